// File: rtl/sc_loader_pkg.sv
// Shared types and constants for the scan-chain loader.
// Holds the FSM state enum, the CRC-8 constants and a one-bit CRC step helper.
package sc_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_VERIFY,
    ST_DONE
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // MSB-first serial CRC-8 update for one input bit
  function automatic logic [7:0] crc8_step(
    input logic [7:0] c,
    input logic       b
  );
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/sc_crc8_serial.sv
// Serial CRC-8 accumulator, one bit per enabled clock.
// Ports: clk, reset (async active-low), clr (sync to init), en, bit_in, crc.
module sc_crc8_serial
  import sc_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] r_crc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_crc <= CRC8_INIT;
    end else if (clr) begin
      r_crc <= CRC8_INIT;
    end else if (en) begin
      r_crc <= crc8_step(r_crc, bit_in);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/sc_chain_loader.sv
// Loads a scan chain from a stream of config words, then rotates it once
// to CRC-check the content. Ports: clk, reset (async active-low),
// cfg_start/cfg_abort controls, cfg_valid/cfg_data/cfg_ready word
// handshake, sc_en/sc_head/sc_tail chain pins, busy/done/err status.
module sc_chain_loader
  import sc_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              sc_en,
  output logic              sc_head,
  input  logic              sc_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int REM       = CHAIN_LEN % WORD_W;
  localparam int LAST_BITS = (REM == 0) ? WORD_W : REM;
  localparam int CW        = $clog2(CHAIN_LEN);
  localparam int BW        = $clog2(WORD_W + 1);
  localparam int NW        = $clog2(NWORDS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CHAIN_LEN - 1);
  localparam logic [BW-1:0] BITS_FULL = BW'(WORD_W);
  localparam logic [BW-1:0] BITS_LAST = BW'(LAST_BITS);
  localparam logic [NW-1:0] WORDS_ALL = NW'(NWORDS);
  localparam logic [NW-1:0] WORD_LAST = NW'(NWORDS - 1);

  state_t            r_state;
  logic [WORD_W-1:0] r_buf;
  logic [BW-1:0]     r_bcnt;
  logic [NW-1:0]     r_wcnt;
  logic [CW-1:0]     r_cnt;
  logic              r_ready;
  logic              r_en;
  logic              r_head;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_acc;
  logic              w_last_bit;
  logic              w_last_word;
  logic [BW-1:0]     w_bcnt_sh;
  logic [WORD_W-1:0] w_buf_sh;
  logic [BW-1:0]     w_nbcnt;
  logic [WORD_W-1:0] w_nbuf;
  logic [NW-1:0]     w_nwcnt;
  logic              w_nfill;
  logic              w_nready;
  logic              w_crc_clr;
  logic              w_ld_en;
  logic              w_vf_en;
  logic [7:0]        w_crc_ld;
  logic [7:0]        w_crc_vf;

  // r_bcnt counts bits still in the buffer, including the one on sc_head
  assign w_acc       = (r_state == ST_SHIFT) && cfg_valid && r_ready;
  assign w_last_bit  = r_en && (r_cnt == CNT_LAST);
  assign w_last_word = (r_wcnt == WORD_LAST);
  assign w_bcnt_sh   = r_en ? r_bcnt - BW'(1) : r_bcnt;
  assign w_buf_sh    = r_en ? r_buf >> 1 : r_buf;
  assign w_nbcnt     = w_acc ? (w_last_word ? BITS_LAST : BITS_FULL)
                             : w_bcnt_sh;
  assign w_nbuf      = w_acc ? cfg_data : w_buf_sh;
  assign w_nwcnt     = w_acc ? r_wcnt + NW'(1) : r_wcnt;
  assign w_nfill     = (w_nbcnt != '0);
  // ready again while the last buffered bit is going out
  assign w_nready    = (w_nbcnt <= BW'(1)) && (w_nwcnt < WORDS_ALL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_buf   <= '0;
      r_bcnt  <= '0;
      r_wcnt  <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_en    <= 1'b0;
      r_head  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (cfg_abort) begin
      r_state <= ST_IDLE;
      r_bcnt  <= '0;
      r_ready <= 1'b0;
      r_en    <= 1'b0;
      r_head  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (cfg_start) begin
            r_state <= ST_SHIFT;
            r_buf   <= '0;
            r_bcnt  <= '0;
            r_wcnt  <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_en    <= 1'b0;
            r_head  <= 1'b0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_last_bit) begin
            r_state <= ST_VERIFY;
            r_bcnt  <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_en    <= 1'b1;
            r_head  <= 1'b0;
          end else begin
            r_buf   <= w_nbuf;
            r_bcnt  <= w_nbcnt;
            r_wcnt  <= w_nwcnt;
            r_ready <= w_nready;
            r_en    <= w_nfill;
            r_head  <= w_nfill & w_nbuf[0];
            if (r_en) r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_VERIFY: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_DONE;
            r_en    <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_err   <= (w_crc_ld != w_crc_vf);
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_en    <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign w_crc_clr = (r_state == ST_IDLE) && cfg_start && !cfg_abort;
  assign w_ld_en   = (r_state == ST_SHIFT) && r_en;
  assign w_vf_en   = (r_state == ST_VERIFY);

  sc_crc8_serial u_crc_ld (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_crc_clr),
    .en     (w_ld_en),
    .bit_in (r_head),
    .crc    (w_crc_ld)
  );

  sc_crc8_serial u_crc_vf (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_crc_clr),
    .en     (w_vf_en),
    .bit_in (sc_tail),
    .crc    (w_crc_vf)
  );

  assign cfg_ready = r_ready;
  assign sc_en     = r_en;
  assign sc_head   = (r_state == ST_VERIFY) ? sc_tail : r_head;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_sc_chain_loader.sv
// Directed bench for sc_chain_loader: two instances (16 and 12 bit chains)
// each driving a behavioural chain model, sharing one stimulus set.
module tb_sc_chain_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       f16 = 1'b0;
  logic       f12 = 1'b0;

  logic rdy16, en16, hd16, bz16, dn16, er16;
  logic rdy12, en12, hd12, bz12, dn12, er12;
  logic [15:0] ch16;
  logic [11:0] ch12;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sc_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_d16 (
    .clk(clk), .reset(rst_n), .cfg_start(start), .cfg_abort(abort),
    .cfg_valid(valid), .cfg_data(data), .cfg_ready(rdy16),
    .sc_en(en16), .sc_head(hd16), .sc_tail(ch16[15]),
    .busy(bz16), .done(dn16), .err(er16)
  );

  sc_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_d12 (
    .clk(clk), .reset(rst_n), .cfg_start(start), .cfg_abort(abort),
    .cfg_valid(valid), .cfg_data(data), .cfg_ready(rdy12),
    .sc_en(en12), .sc_head(hd12), .sc_tail(ch12[11]),
    .busy(bz12), .done(dn12), .err(er12)
  );

  // chain models: index 0 is the head flip-flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ch16 <= '0;
    else if (en16) ch16 <= {ch16[14:0], hd16} ^ (f16 ? 16'h0008 : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ch12 <= '0;
    else if (en12) ch12 <= {ch12[10:0], hd12} ^ (f12 ? 12'h008 : 12'h000);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One load of two words; cycle k = period ending at edge k, edge 0
  // samples cfg_start.
  task automatic run_load(
    input  bit         sel,
    input  logic [7:0] w0,
    input  logic [7:0] w1,
    input  int         gap,
    input  int         flip_at,
    input  int         abort_at,
    input  int         restart_at,
    output int         done_cyc,
    output int         ndone,
    output int         first_en,
    output int         en_low,
    output int         nacc,
    output logic       ab_busy,
    output logic       err_c1
  );
    int   widx;
    int   g;
    logic b_en, b_dn, b_bz, b_rdy, b_er;
    logic [7:0] words [2];
    words[0] = w0;
    words[1] = w1;
    widx = 0;
    g = gap;
    done_cyc = -1;
    ndone = 0;
    first_en = -1;
    en_low = 0;
    nacc = 0;
    ab_busy = 1'b0;
    err_c1 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      b_en  = sel ? en12 : en16;
      b_dn  = sel ? dn12 : dn16;
      b_bz  = sel ? bz12 : bz16;
      b_rdy = sel ? rdy12 : rdy16;
      b_er  = sel ? er12 : er16;
      if (b_dn) begin
        ndone++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (b_en && first_en < 0) first_en = k;
      if (!b_en && first_en >= 0 && done_cyc < 0) en_low++;
      if (k == abort_at + 1) ab_busy = b_bz;
      if (k == 1) err_c1 = b_er;
      start = (k == restart_at);
      abort = (k == abort_at);
      f16 = (k == flip_at) && !sel;
      f12 = (k == flip_at) && sel;
      valid = 1'b0;
      data = 8'h00;
      if (widx < 2) begin
        if (widx > 0 && b_rdy && g > 0) g--;
        else begin
          valid = 1'b1;
          data = words[widx];
        end
      end
      if (valid && b_rdy) begin
        nacc++;
        widx++;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    f16 = 1'b0;
    f12 = 1'b0;
    valid = 1'b0;
  endtask

  int   dc, nd, fe, el, na;
  logic ab, e1;

  initial begin
    #12;
    chk("rst_busy", bz16, 1'b0);
    chk("rst_done", dn16, 1'b0);
    chk("rst_err", er16, 1'b0);
    chk("rst_ready", rdy16, 1'b0);
    chk("rst_en", en16, 1'b0);
    chk("rst_head", hd16, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // valid without start is ignored
    valid = 1'b1;
    data = 8'hFF;
    repeat (3) @(negedge clk);
    chk("idle_ready", rdy16, 1'b0);
    chk("idle_en", en16, 1'b0);
    chk("idle_busy", bz16, 1'b0);
    valid = 1'b0;

    // back-to-back, with a stray start while busy
    run_load(1'b0, 8'hA5, 8'h3C, 0, -1, -10, 10,
             dc, nd, fe, el, na, ab, e1);
    chk("b2b_done_cyc", dc, 34);
    chk("b2b_ndone", nd, 1);
    chk("b2b_first_en", fe, 2);
    chk("b2b_en_low", el, 0);
    chk("b2b_nacc", na, 2);
    chk("b2b_err", er16, 1'b0);
    chk("b2b_busy_end", bz16, 1'b0);
    chk("b2b_chain", ch16, 16'hA53C);

    // five-cycle stall between words
    run_load(1'b0, 8'hA5, 8'h3C, 5, -1, -10, -1,
             dc, nd, fe, el, na, ab, e1);
    chk("stall_done_cyc", dc, 39);
    chk("stall_en_low", el, 5);
    chk("stall_chain", ch16, 16'hA53C);
    chk("stall_err", er16, 1'b0);

    // partial last word on the 12-bit chain
    run_load(1'b1, 8'h5A, 8'hFF, 0, -1, -10, -1,
             dc, nd, fe, el, na, ab, e1);
    chk("part_done_cyc", dc, 26);
    chk("part_nacc", na, 2);
    chk("part_chain", ch12, 12'h5AF);
    chk("part_err", er12, 1'b0);

    // chain fault injected during verify
    run_load(1'b0, 8'hA5, 8'h3C, 0, 20, -10, -1,
             dc, nd, fe, el, na, ab, e1);
    chk("fault_done_cyc", dc, 34);
    chk("fault_err", er16, 1'b1);
    repeat (3) @(negedge clk);
    chk("fault_err_hold", er16, 1'b1);

    run_load(1'b0, 8'hA5, 8'h3C, 0, -1, -10, -1,
             dc, nd, fe, el, na, ab, e1);
    chk("post_fault_err_c1", e1, 1'b0);
    chk("post_fault_err", er16, 1'b0);
    chk("post_fault_chain", ch16, 16'hA53C);

    // abort in cycle 6
    run_load(1'b0, 8'hA5, 8'h3C, 0, -1, 6, -1,
             dc, nd, fe, el, na, ab, e1);
    chk("abort_busy", ab, 1'b0);
    chk("abort_ndone", nd, 0);
    chk("abort_nacc", na, 1);
    chk("abort_err", er16, 1'b0);

    run_load(1'b0, 8'hA5, 8'h3C, 0, -1, -10, -1,
             dc, nd, fe, el, na, ab, e1);
    chk("post_abort_done", dc, 34);
    chk("post_abort_chain", ch16, 16'hA53C);

    // asynchronous reset in cycle 20 (mid verify)
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bz16, 1'b0);
    chk("arst_en", en16, 1'b0);
    chk("arst_head", hd16, 1'b0);
    chk("arst_ready", rdy16, 1'b0);
    chk("arst_done", dn16, 1'b0);
    chk("arst_err", er16, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_load(1'b0, 8'hA5, 8'h3C, 0, -1, -10, -1,
             dc, nd, fe, el, na, ab, e1);
    chk("post_rst_done", dc, 34);
    chk("post_rst_chain", ch16, 16'hA53C);
    chk("post_rst_err", er16, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sc_chain_loader.md
SC_CHAIN_LOADER -- requirements
Module: sc_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 64: number of scan-chain flip-flops driven, legal range 2..4096.
REQ-002 Parameter WORD_W, default 8: configuration word width, legal range 1..32.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cfg_start  input  1  one-cycle pulse that begins a load; sampled only in IDLE.
REQ-006 cfg_abort  input  1  returns the block to IDLE from any state.
REQ-007 cfg_valid  input  1  cfg_data is valid.
REQ-008 cfg_data  input  WORD_W  configuration word, shifted LSB first.
REQ-009 cfg_ready  output  1  the block accepts cfg_data this cycle.
REQ-010 sc_en  output  1  the chain shifts on this clk edge.
REQ-011 sc_head  output  1  serial data into the D input of the first chain flip-flop.
REQ-012 sc_tail  input  1  Q of the last chain flip-flop.
REQ-013 busy  output  1  high in every state other than IDLE.
REQ-014 done  output  1  one-cycle pulse when a load and verify completes.
REQ-015 err  output  1  verify CRC mismatch; held until the next accepted cfg_start or reset.

Function
REQ-016 FSM states: IDLE, SHIFT, VERIFY, DONE; cfg_start in IDLE goes to SHIFT on the next cycle and clears err.
REQ-017 SHIFT state:
- cfg_ready = 1 when the word buffer is empty, or when the buffer is shifting its last bit with sc_en high.
- A word is accepted on the edge where cfg_valid and cfg_ready are both high.
REQ-018 SHIFT data path:
- Word bits drive sc_head one bit per cycle, starting the cycle after acceptance.
- sc_en is high only while the buffer holds bits.
- sc_en is low during stalls, so the chain holds.
REQ-019 Word count is ceil(CHAIN_LEN/WORD_W). In the final word only the low (CHAIN_LEN mod WORD_W) bits are shifted, or all bits if the remainder is 0; the upper bits are discarded.
REQ-020 Bit count and CRC:
- A bit counter counts exactly CHAIN_LEN shifted bits.
- A serial CRC-8 (poly 0x07, init 0x00) is accumulated over sc_head bits in shift order.
REQ-021 When CHAIN_LEN bits have been shifted, the FSM enters VERIFY and cfg_ready stays 0 until the next load.
REQ-022 VERIFY state:
- sc_head = sc_tail and sc_en = 1 for exactly CHAIN_LEN cycles, which rotates the chain back to its loaded content.
- A second CRC-8 is accumulated over sc_tail.
REQ-023 After VERIFY the FSM enters DONE for one cycle:
- done = 1.
- err = 1 if the two CRCs differ.
- Then the FSM returns to IDLE.
REQ-024 Back-to-back timing: with cfg_start at edge 0 and cfg_valid held high, CHAIN_LEN=16 and WORD_W=8 give:
- word0 accepted in cycle 1, sc_en high in cycles 2..17;
- VERIFY in cycles 18..33;
- done in cycle 34.
REQ-025 cfg_start is ignored while busy. cfg_abort has priority over all transitions: next state is IDLE, sc_en = 0, done is not pulsed, err is unchanged, and chain content is undefined.
REQ-026 cfg_valid without a prior start is ignored (cfg_ready = 0 in IDLE).

Reset
REQ-027 While reset is low:
- state = IDLE and all counters, the buffer and both CRCs are cleared;
- cfg_ready = 0, sc_en = 0, sc_head = 0, busy = 0, done = 0, err = 0.
REQ-028 Reset asserted mid-SHIFT or mid-VERIFY aborts immediately. Chain content is undefined and the block does not recover it.

Structure
REQ-029 Shared package sc_loader_pkg holds the FSM state enum, CRC8_POLY = 8'h07 and CRC8_INIT = 8'h00.
REQ-030 The serial CRC is a sub-module sc_crc8_serial (clk, reset, clr, en, bit_in, crc), instantiated twice: once for load, once for verify.
REQ-031 All outputs except sc_head in VERIFY are driven from registers; sc_head in VERIFY is a combinational pass of sc_tail.

Verification
REQ-032 The bench models the chain as CHAIN_LEN flip-flops shifting on sc_en, using the same reset.
REQ-033 Back-to-back load: CHAIN_LEN=16, WORD_W=8, words 0xA5, 0x3C -> done at cycle 34, err=0, chain holds bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 from far end to head.
REQ-034 Stall: 5 idle cycles of cfg_valid between words -> sc_en low for 5 cycles, identical chain content, done at cycle 39.
REQ-035 Partial last word: CHAIN_LEN=12, words 0x5A, 0xFF -> 2 handshakes, only 4 bits of 0xFF shifted, done at cycle 26, err=0.
REQ-036 Fault: the chain model flips flip-flop 3 during VERIFY -> err=1 after done and stays 1 until the next cfg_start.
REQ-037 Abort and reset mid-operation:
- cfg_abort in cycle 6 -> IDLE next cycle, no done pulse, busy=0.
- reset low in cycle 20 -> all outputs 0 asynchronously.
- A new cfg_start after either succeeds.
